// File: rtl/obstacle_spawner_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | obstacle_spawner_pkg: shared game types and lane-to-x mapping.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package obstacle_spawner_pkg;

    localparam int LANE_BITS = 4;
    localparam int X_BITS    = 10;
    localparam int SCREEN_W  = 640;

    typedef logic [LANE_BITS-1:0] lane_t;
    typedef logic [X_BITS-1:0]    xpos_t;

    // Also used by the collision stage; result wraps at X_BITS.
    function automatic xpos_t lane_to_x(input lane_t lane, input xpos_t x_min, input xpos_t lane_w);
        xpos_t lane_ext;
        lane_ext = xpos_t'(lane);
        return x_min + lane_ext * lane_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/obstacle_spawner_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | obstacle_spawner_if: valid/ready spawn-request channel.            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface obstacle_spawner_if;
    import obstacle_spawner_pkg::*;

    logic  obs_valid;
    logic  obs_ready;
    lane_t obs_lane;
    xpos_t obs_x;

    modport master (output obs_valid, output obs_lane, output obs_x, input obs_ready);
    modport slave  (input obs_valid, input obs_lane, input obs_x, output obs_ready);

endinterface
`default_nettype wire

// File: rtl/obstacle_spawner_spawn_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | obstacle_spawner_spawn_fifo: lane FIFO; a push while full is kept  |
// | when a pop happens on the same edge. Rev 1.0                       |
// +--------------------------------------------------------------------+
module obstacle_spawner_spawn_fifo
    import obstacle_spawner_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic                 clk,
    input  wire logic                 reset_n,
    input  wire logic                 push_i,
    input  wire logic                 pop_i,
    input  wire lane_t                data_i,
    output lane_t                     data_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      empty_o,
    output logic                      drop_o
);

    localparam int                PW     = $clog2(DEPTH);
    localparam logic [PW:0]       c_FULL = (PW+1)'(DEPTH);

    lane_t         mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;

    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;
    logic [PW-1:0] w_head_idx;

    assign w_full  = (count_q == c_FULL);
    assign w_empty = (count_q == '0);
    assign w_pop   = pop_i & ~w_empty;
    assign w_push  = push_i & (~w_full | w_pop);

    // When empty, the slot behind rd_ptr still holds the last popped entry.
    assign w_head_idx = w_empty ? (rd_ptr_q - PW'(1)) : rd_ptr_q;

    assign data_o  = mem_q[w_head_idx];
    assign count_o = count_q;
    assign empty_o = w_empty;
    assign drop_o  = push_i & ~w_push;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (w_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (w_push && !w_pop) begin
                count_q <= count_q + (PW+1)'(1);
            end else if (w_pop && !w_push) begin
                count_q <= count_q - (PW+1)'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/obstacle_spawner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | obstacle_spawner: periodic random-lane spawn requests to the game. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module obstacle_spawner
    import obstacle_spawner_pkg::*;
#(
    parameter int    SPAWN_PERIOD = 8,
    parameter int    FIFO_DEPTH   = 4,
    parameter xpos_t X_MIN        = 10'd16,
    parameter xpos_t LANE_W       = 10'd36
) (
    input  wire logic            clk,
    input  wire logic            reset_n,
    input  wire logic            enable_i,
    input  wire logic            frame_tick_i,
    input  wire lane_t           rand_in_i,
    obstacle_spawner_if.master   obs_if,
    output logic [3:0]           fifo_count_o,
    output logic                 overflow_o
);

    localparam logic [7:0] c_PERIOD_LAST = 8'(SPAWN_PERIOD - 1);

    logic [7:0] period_q;
    logic [7:0] period_d;
    lane_t      rand_q;
    lane_t      last_lane_q;
    logic       overflow_q;

    logic       w_tick;
    logic       w_spawn;
    lane_t      w_lane;
    lane_t      w_head;
    logic       w_empty;
    logic       w_drop;
    logic [$clog2(FIFO_DEPTH):0] w_count;

    assign w_tick  = enable_i & frame_tick_i;
    assign w_spawn = w_tick & (period_q == c_PERIOD_LAST);

    // Never repeat the previous lane back to back.
    assign w_lane = (rand_q == last_lane_q) ? lane_t'(rand_q + 4'd1) : rand_q;

    always_comb begin
        period_d = period_q;
        if (w_tick) begin
            period_d = w_spawn ? 8'd0 : period_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_q    <= '0;
            rand_q      <= '0;
            last_lane_q <= 4'd15;
            overflow_q  <= 1'b0;
        end else begin
            period_q <= period_d;
            rand_q   <= rand_in_i;
            if (w_spawn) begin
                last_lane_q <= w_lane;
            end
            if (w_drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    obstacle_spawner_spawn_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (w_spawn),
        .pop_i   (obs_if.obs_ready),
        .data_i  (w_lane),
        .data_o  (w_head),
        .count_o (w_count),
        .empty_o (w_empty),
        .drop_o  (w_drop)
    );

    assign obs_if.obs_valid = ~w_empty;
    assign obs_if.obs_lane  = w_head;
    assign obs_if.obs_x     = lane_to_x(w_head, X_MIN, LANE_W);
    assign fifo_count_o     = 4'(w_count);
    assign overflow_o       = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_obstacle_spawner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_obstacle_spawner: directed + random bench with queue model.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_obstacle_spawner;
    import obstacle_spawner_pkg::*;

    localparam int PERIOD = 8;
    localparam int DEPTH  = 4;

    logic       clk          = 1'b0;
    logic       reset_n      = 1'b0;
    logic       enable_i     = 1'b0;
    logic       frame_tick_i = 1'b0;
    lane_t      rand_in_i    = '0;
    logic [3:0] fifo_count_o;
    logic       overflow_o;

    obstacle_spawner_if obs_if ();

    obstacle_spawner #(
        .SPAWN_PERIOD (PERIOD),
        .FIFO_DEPTH   (DEPTH),
        .X_MIN        (10'd16),
        .LANE_W       (10'd36)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable_i     (enable_i),
        .frame_tick_i (frame_tick_i),
        .rand_in_i    (rand_in_i),
        .obs_if       (obs_if),
        .fifo_count_o (fifo_count_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: ticks seen this period, sampled random value, last lane, pending queue.
    int m_ticks;
    int m_rand;
    int m_last;
    int m_q[$];
    bit m_over;

    task automatic check_value(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_ticks = 0;
        m_rand  = 0;
        m_last  = 15;
        m_q.delete();
        m_over  = 1'b0;
    endtask

    task automatic compare_all();
        check_value("valid", int'(obs_if.obs_valid), (m_q.size() > 0) ? 1 : 0);
        check_value("count", int'(fifo_count_o), m_q.size());
        check_value("overflow", int'(overflow_o), int'(m_over));
        if (m_q.size() > 0) begin
            check_value("lane", int'(obs_if.obs_lane), m_q[0]);
            check_value("x", int'(obs_if.obs_x), 16 + 36 * m_q[0]);
        end
    endtask

    task automatic step(input bit en, input bit tk, input int r, input bit rdy);
        bit pop;
        bit spawn;
        int lane;
        enable_i         = en;
        frame_tick_i     = tk;
        rand_in_i        = lane_t'(r);
        obs_if.obs_ready = rdy;
        pop   = rdy && (m_q.size() > 0);
        spawn = 1'b0;
        if (en && tk) begin
            m_ticks++;
            if (m_ticks == PERIOD) begin
                m_ticks = 0;
                spawn   = 1'b1;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (spawn) begin
            lane   = (m_rand == m_last) ? (m_rand + 1) % 16 : m_rand;
            m_last = lane;
            if (m_q.size() < DEPTH) m_q.push_back(lane);
            else m_over = 1'b1;
        end
        m_rand = r;
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic frame(input bit en, input int r, input bit rdy);
        step(en, 1'b1, r, rdy);
        step(en, 1'b0, r, rdy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n          = 1'b0;
        enable_i         = 1'b0;
        frame_tick_i     = 1'b0;
        rand_in_i        = '0;
        obs_if.obs_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        obs_if.obs_ready = 1'b0;
        do_reset();
        check_value("rst_valid", int'(obs_if.obs_valid), 0);
        check_value("rst_lane", int'(obs_if.obs_lane), 0);
        check_value("rst_x", int'(obs_if.obs_x), 16);
        check_value("rst_count", int'(fifo_count_o), 0);
        check_value("rst_overflow", int'(overflow_o), 0);

        // Basic spawn and pop latency.
        step(1'b1, 1'b0, 5, 1'b1);
        for (int i = 0; i < 7; i++) frame(1'b1, 5, 1'b1);
        step(1'b1, 1'b1, 5, 1'b1);
        check_value("t1_valid", int'(obs_if.obs_valid), 1);
        check_value("t1_lane", int'(obs_if.obs_lane), 5);
        check_value("t1_x", int'(obs_if.obs_x), 196);
        step(1'b1, 1'b0, 5, 1'b1);
        check_value("t1_popped", int'(fifo_count_o), 0);

        // Repeat-lane rule.
        for (int i = 0; i < 2 * PERIOD; i++) frame(1'b1, 15, 1'b0);
        check_value("t2_count", int'(fifo_count_o), 2);
        check_value("t2_head_lane", int'(obs_if.obs_lane), 15);
        check_value("t2_head_x", int'(obs_if.obs_x), 556);
        for (int i = 0; i < PERIOD; i++) frame(1'b1, 0, 1'b0);
        check_value("t2_count3", int'(fifo_count_o), 3);
        step(1'b1, 1'b0, 0, 1'b1);
        check_value("t2_second_lane", int'(obs_if.obs_lane), 0);
        check_value("t2_second_x", int'(obs_if.obs_x), 16);
        step(1'b1, 1'b0, 0, 1'b1);
        check_value("t2_third_lane", int'(obs_if.obs_lane), 1);
        step(1'b1, 1'b0, 0, 1'b1);

        // Overflow: five spawns into a four-deep FIFO, then drain.
        do_reset();
        for (int i = 0; i < 5 * PERIOD; i++) frame(1'b1, int'($urandom_range(0, 15)), 1'b0);
        check_value("t3_count", int'(fifo_count_o), 4);
        check_value("t3_overflow", int'(overflow_o), 1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 3, 1'b1);
        check_value("t3_drained", int'(fifo_count_o), 0);

        // Full FIFO with a pop on the spawn edge.
        do_reset();
        for (int i = 0; i < 4 * PERIOD + PERIOD - 1; i++) frame(1'b1, int'($urandom_range(0, 15)), 1'b0);
        step(1'b1, 1'b1, 9, 1'b1);
        check_value("t4_count", int'(fifo_count_o), 4);
        check_value("t4_overflow", int'(overflow_o), 0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 9, 1'b1);

        // Enable gating mid-period.
        do_reset();
        for (int i = 0; i < 3; i++) frame(1'b1, 7, 1'b0);
        for (int i = 0; i < 20; i++) frame(1'b0, 7, 1'b0);
        for (int i = 0; i < 4; i++) frame(1'b1, 7, 1'b0);
        check_value("t5_no_spawn", int'(obs_if.obs_valid), 0);
        frame(1'b1, 7, 1'b0);
        check_value("t5_spawn", int'(obs_if.obs_valid), 1);

        // Asynchronous reset between edges with three entries pending.
        do_reset();
        for (int i = 0; i < 5 * PERIOD; i++) frame(1'b1, int'($urandom_range(0, 15)), 1'b0);
        step(1'b1, 1'b0, 2, 1'b1);
        step(1'b1, 1'b0, 2, 1'b0);
        check_value("t6_pre_count", int'(fifo_count_o), 3);
        #3;
        reset_n = 1'b0;
        #1;
        check_value("t6_valid", int'(obs_if.obs_valid), 0);
        check_value("t6_count", int'(fifo_count_o), 0);
        check_value("t6_overflow", int'(overflow_o), 0);
        do_reset();

        // Random traffic: light consumer first, then a heavy one.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0,
                 int'($urandom_range(0, 15)),
                 (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
